uart_frame_parser: RTL and testbench

Byte-level frame parser that sits directly downstream of the UART receiver. Consumes the receiver's single-cycle byte strobe, hunts for a start-of-frame byte, collects length, command and payload, and verifies an XOR checksum. A good frame's payload is then replayed on a valid/ready byte stream with the command held alongside. Bad or stalled frames are dropped and reported.

---
 rtl/uart_frame_pkg.sv | 25 ++
 rtl/uart_frame_buf.sv | 32 +++
 rtl/uart_frame_parser.sv | 166 ++++++++++++++++
 tb/tb_uart_frame_parser.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_frame_pkg.sv
// Shared constants, error codes and parser state encoding for the UART frame parser.
package uart_frame_pkg;

  localparam logic [7:0] SOF = 8'hA5;

  localparam logic [1:0] ERR_NONE = 2'b00;
  localparam logic [1:0] ERR_LEN  = 2'b01;
  localparam logic [1:0] ERR_CHK  = 2'b10;
  localparam logic [1:0] ERR_TMO  = 2'b11;

  typedef enum logic [2:0] {
    HUNT  = 3'd0,
    LEN   = 3'd1,
    CMD   = 3'd2,
    PAY   = 3'd3,
    CHK   = 3'd4,
    DRAIN = 3'd5
  } state_t;

  // A length byte is unusable if it is zero or exceeds the payload buffer.
  function automatic logic len_bad(input logic [7:0] b, input int max_len);
    return (b == 8'h00) || (int'(b) > max_len);
  endfunction

endpackage

// File: rtl/uart_frame_buf.sv
// Payload store: register array with one synchronous write port and a combinational read port.
module uart_frame_buf #(
  parameter int DEPTH = 16,
  parameter int IDX_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             i_we,
  input  logic [IDX_W-1:0] i_wr_idx,
  input  logic [7:0]       i_wr_data,
  input  logic [IDX_W-1:0] i_rd_idx,
  output logic [7:0]       o_rd_data
);

  logic [7:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (i_wr_idx == IDX_W'(i)) r_mem[i] <= i_wr_data;
      end
    end
  end

  // Index is one bit wider than the depth needs, so decode by compare instead of direct indexing.
  always_comb begin
    o_rd_data = 8'h00;
    for (int i = 0; i < DEPTH; i++) begin
      if (i_rd_idx == IDX_W'(i)) o_rd_data = r_mem[i];
    end
  end

endmodule

// File: rtl/uart_frame_parser.sv
// Frame parser behind the UART receiver: SOF hunt, LEN/CMD/payload capture, XOR check,
// then replay of the payload on a valid/ready stream with the command held alongside.
module uart_frame_parser
  import uart_frame_pkg::*;
#(
  parameter int MAX_LEN        = 16,
  parameter int TIMEOUT_CYCLES = 10000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx_data_ready,
  input  logic [7:0] rx_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_data,
  output logic       out_last,
  output logic [7:0] out_cmd,
  output logic [7:0] out_len,
  output logic       frame_ok,
  output logic       frame_err,
  output logic [1:0] err_code,
  output logic       overrun
);

  localparam int IDX_W = $clog2(MAX_LEN + 1);
  localparam int GAP_W = $clog2(TIMEOUT_CYCLES);

  state_t           r_state, w_state_next;
  logic [7:0]       r_len, r_cmd, r_chk;
  logic [IDX_W-1:0] r_wr_idx, r_rd_idx;
  logic [GAP_W-1:0] r_gap;
  logic             r_frame_ok, r_frame_err, r_overrun;
  logic [1:0]       r_err_code;

  logic       w_counting, w_timeout, w_len_bad, w_wr_last, w_rd_last;
  logic       w_chk_match, w_handshake, w_buf_we;
  logic [7:0] w_rd_data;

  assign w_counting  = (r_state == LEN) || (r_state == CMD) || (r_state == PAY) || (r_state == CHK);
  // A strobe in the final gap cycle wins over the timeout.
  assign w_timeout   = w_counting && !rx_data_ready && (r_gap == GAP_W'(TIMEOUT_CYCLES - 1));
  assign w_len_bad   = len_bad(rx_data, MAX_LEN);
  assign w_wr_last   = (8'(r_wr_idx) == (r_len - 8'd1));
  assign w_rd_last   = (8'(r_rd_idx) == (r_len - 8'd1));
  assign w_chk_match = (rx_data == r_chk);
  assign w_handshake = out_valid && out_ready;

  uart_frame_buf #(
    .DEPTH (MAX_LEN),
    .IDX_W (IDX_W)
  ) u_buf (
    .clk       (clk),
    .i_we      (w_buf_we),
    .i_wr_idx  (r_wr_idx),
    .i_wr_data (rx_data),
    .i_rd_idx  (r_rd_idx),
    .o_rd_data (w_rd_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= HUNT;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      HUNT: if (rx_data_ready && rx_data == SOF) w_state_next = LEN;
      LEN: begin
        if (rx_data_ready) w_state_next = w_len_bad ? HUNT : CMD;
        else if (w_timeout) w_state_next = HUNT;
      end
      CMD: begin
        if (rx_data_ready) w_state_next = PAY;
        else if (w_timeout) w_state_next = HUNT;
      end
      PAY: begin
        if (rx_data_ready && w_wr_last) w_state_next = CHK;
        else if (w_timeout) w_state_next = HUNT;
      end
      CHK: begin
        if (rx_data_ready) w_state_next = w_chk_match ? DRAIN : HUNT;
        else if (w_timeout) w_state_next = HUNT;
      end
      DRAIN: if (w_handshake && w_rd_last) w_state_next = HUNT;
      default: w_state_next = HUNT;
    endcase
  end

  always_comb begin
    out_valid = (r_state == DRAIN);
    out_last  = out_valid && w_rd_last;
    out_data  = out_valid ? w_rd_data : 8'h00;
    w_buf_we  = (r_state == PAY) && rx_data_ready;
    out_cmd   = r_cmd;
    out_len   = r_len;
    frame_ok  = r_frame_ok;
    frame_err = r_frame_err;
    err_code  = r_err_code;
    overrun   = r_overrun;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_len       <= 8'h00;
      r_cmd       <= 8'h00;
      r_chk       <= 8'h00;
      r_wr_idx    <= '0;
      r_rd_idx    <= '0;
      r_gap       <= '0;
      r_frame_ok  <= 1'b0;
      r_frame_err <= 1'b0;
      r_err_code  <= ERR_NONE;
      r_overrun   <= 1'b0;
    end else begin
      r_frame_ok  <= 1'b0;
      r_frame_err <= 1'b0;
      r_err_code  <= ERR_NONE;
      r_overrun   <= 1'b0;

      if (!w_counting || rx_data_ready || w_timeout) r_gap <= '0;
      else                                           r_gap <= r_gap + GAP_W'(1);

      if (w_timeout) begin
        r_frame_err <= 1'b1;
        r_err_code  <= ERR_TMO;
      end

      unique case (r_state)
        LEN: if (rx_data_ready) begin
          if (w_len_bad) begin
            r_frame_err <= 1'b1;
            r_err_code  <= ERR_LEN;
          end else begin
            r_len <= rx_data;
            r_chk <= rx_data;
          end
        end
        CMD: if (rx_data_ready) begin
          r_cmd    <= rx_data;
          r_chk    <= r_chk ^ rx_data;
          r_wr_idx <= '0;
        end
        PAY: if (rx_data_ready) begin
          r_chk    <= r_chk ^ rx_data;
          r_wr_idx <= r_wr_idx + IDX_W'(1);
        end
        CHK: if (rx_data_ready) begin
          if (w_chk_match) begin
            r_frame_ok <= 1'b1;
            r_rd_idx   <= '0;
          end else begin
            r_frame_err <= 1'b1;
            r_err_code  <= ERR_CHK;
          end
        end
        DRAIN: begin
          if (rx_data_ready) r_overrun <= 1'b1;
          if (w_handshake)   r_rd_idx  <= r_rd_idx + IDX_W'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_frame_parser.sv
// Directed bench for uart_frame_parser: good/bad frames, noise, timeout, backpressure, reset.
module tb_uart_frame_parser;

  localparam int T_CYC = 20;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rx_data_ready;
  logic [7:0] rx_data;
  logic       out_valid, out_ready, out_last;
  logic [7:0] out_data, out_cmd, out_len;
  logic       frame_ok, frame_err, overrun;
  logic [1:0] err_code;

  int n_tests = 0;
  int n_fail  = 0;

  uart_frame_parser #(
    .MAX_LEN        (16),
    .TIMEOUT_CYCLES (T_CYC)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .rx_data_ready (rx_data_ready),
    .rx_data       (rx_data),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_data      (out_data),
    .out_last      (out_last),
    .out_cmd       (out_cmd),
    .out_len       (out_len),
    .frame_ok      (frame_ok),
    .frame_err     (frame_err),
    .err_code      (err_code),
    .overrun       (overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One-cycle byte strobe; returns just after the consuming edge.
  task automatic send(input logic [7:0] b);
    rx_data_ready = 1'b1;
    rx_data       = b;
    step();
    rx_data_ready = 1'b0;
    rx_data       = 8'h00;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    rst_n = 1'b0;
    rx_data_ready = 1'b0;
    rx_data = 8'h00;
    out_ready = 1'b0;
    repeat (3) step();
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_data",  out_data,  8'h00);
    chk("rst_last",  out_last,  1'b0);
    chk("rst_cmd",   out_cmd,   8'h00);
    chk("rst_len",   out_len,   8'h00);
    chk("rst_ok",    frame_ok,  1'b0);
    chk("rst_err",   frame_err, 1'b0);
    chk("rst_code",  err_code,  2'b00);
    chk("rst_ovr",   overrun,   1'b0);
    rst_n = 1'b1;
    step();

    // Good frame, streaming at full rate
    out_ready = 1'b1;
    send(8'hA5); send(8'h03); send(8'h10); send(8'h11); send(8'h22); send(8'h33);
    chk("good_no_ok_early", frame_ok, 1'b0);
    send(8'h13);
    chk("good_ok",    frame_ok,  1'b1);
    chk("good_valid", out_valid, 1'b1);
    chk("good_cmd",   out_cmd,   8'h10);
    chk("good_len",   out_len,   8'h03);
    chk("good_d0",    out_data,  8'h11);
    chk("good_l0",    out_last,  1'b0);
    step();
    chk("good_ok_pulse", frame_ok, 1'b0);
    chk("good_d1", out_data, 8'h22);
    chk("good_l1", out_last, 1'b0);
    step();
    chk("good_d2", out_data, 8'h33);
    chk("good_l2", out_last, 1'b1);
    step();
    chk("good_done", out_valid, 1'b0);

    // Bad checksum then a 1-byte frame
    send(8'hA5); send(8'h03); send(8'h10); send(8'h11); send(8'h22); send(8'h33); send(8'h14);
    chk("bchk_err",   frame_err, 1'b1);
    chk("bchk_code",  err_code,  2'b10);
    chk("bchk_valid", out_valid, 1'b0);
    step();
    chk("bchk_err_pulse", frame_err, 1'b0);
    chk("bchk_valid2",    out_valid, 1'b0);
    send(8'hA5); send(8'h01); send(8'h40); send(8'h7E); send(8'h3F);
    chk("one_ok",   frame_ok, 1'b1);
    chk("one_data", out_data, 8'h7E);
    chk("one_last", out_last, 1'b1);
    chk("one_cmd",  out_cmd,  8'h40);
    chk("one_len",  out_len,  8'h01);
    step();
    chk("one_done", out_valid, 1'b0);

    // Noise and bad lengths
    send(8'h00);
    chk("noise00_err", frame_err, 1'b0);
    send(8'hFF);
    chk("noiseFF_err", frame_err, 1'b0);
    send(8'hA5); send(8'h00);
    chk("len0_err",  frame_err, 1'b1);
    chk("len0_code", err_code,  2'b01);
    send(8'hA5);
    chk("len0_pulse", frame_err, 1'b0);
    send(8'h11);
    chk("len17_err",  frame_err, 1'b1);
    chk("len17_code", err_code,  2'b01);

    // Timeout: error appears exactly T_CYC cycles after the last strobe
    send(8'hA5); send(8'h02); send(8'h20); send(8'h55);
    cnt = 0;
    while (cnt < 3 * T_CYC && !frame_err) begin
      step();
      cnt++;
    end
    chk("tmo_latency", cnt, T_CYC);
    chk("tmo_code", err_code, 2'b11);
    step();
    chk("tmo_pulse", frame_err, 1'b0);

    // Strobe on the final gap cycle keeps the frame alive
    send(8'hA5); send(8'h02); send(8'h20); send(8'h55);
    repeat (T_CYC - 1) step();
    send(8'h66);
    chk("tmo_suppressed", frame_err, 1'b0);
    send(8'h11);
    chk("late_ok",   frame_ok, 1'b1);
    chk("late_d0",   out_data, 8'h55);
    step();
    chk("late_d1",   out_data, 8'h66);
    chk("late_l1",   out_last, 1'b1);
    step();
    chk("late_done", out_valid, 1'b0);

    // Backpressure stall with an overrun byte
    out_ready = 1'b0;
    send(8'hA5); send(8'h03); send(8'h10); send(8'h11); send(8'h22); send(8'h33); send(8'h13);
    chk("bp_ok", frame_ok, 1'b1);
    step();
    chk("bp_hold1", out_data, 8'h11);
    send(8'hA5);
    chk("bp_ovr",   overrun,  1'b1);
    chk("bp_hold2", out_data, 8'h11);
    step();
    chk("bp_ovr_pulse", overrun,  1'b0);
    chk("bp_hold3",     out_data, 8'h11);
    step();
    chk("bp_hold4", out_data,  8'h11);
    chk("bp_last4", out_last,  1'b0);
    chk("bp_valid", out_valid, 1'b1);
    out_ready = 1'b1;
    step();
    chk("bp_d1", out_data, 8'h22);
    step();
    chk("bp_d2", out_data, 8'h33);
    chk("bp_l2", out_last, 1'b1);
    step();
    chk("bp_done", out_valid, 1'b0);
    chk("bp_no_ovr", overrun, 1'b0);

    // Reset mid-PAY: rest of the frame must be ignored after release
    send(8'hA5); send(8'h03); send(8'h10); send(8'h11);
    #2 rst_n = 1'b0;
    #1;
    chk("rpay_cmd", out_cmd, 8'h00);
    chk("rpay_len", out_len, 8'h00);
    step();
    rst_n = 1'b1;
    send(8'h22); send(8'h33); send(8'h13);
    chk("rpay_no_ok", frame_ok,  1'b0);
    chk("rpay_idle",  out_valid, 1'b0);

    // Reset mid-DRAIN
    out_ready = 1'b0;
    send(8'hA5); send(8'h03); send(8'h10); send(8'h11); send(8'h22); send(8'h33); send(8'h13);
    chk("rdr_valid_pre", out_valid, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("rdr_valid", out_valid, 1'b0);
    chk("rdr_data",  out_data,  8'h00);
    chk("rdr_ok",    frame_ok,  1'b0);
    chk("rdr_cmd",   out_cmd,   8'h00);
    step();
    rst_n = 1'b1;
    step();
    chk("rdr_idle", out_valid, 1'b0);
    out_ready = 1'b1;
    send(8'hA5); send(8'h01); send(8'h40); send(8'h7E); send(8'h3F);
    chk("post_ok",   frame_ok, 1'b1);
    chk("post_data", out_data, 8'h7E);
    chk("post_last", out_last, 1'b1);
    step();
    chk("post_done", out_valid, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
